// File: rtl/fetch_line_buffer.sv
// Instruction fetch unit: issues Sysbus line bursts, splits beats into 32-bit instructions
// and queues {instr, pc} in a FIFO toward decode, with redirect/drain and zero-word halt.
module fetch_line_buffer #(
    parameter int         BUS_DATA_WIDTH = 64,
    parameter int         BUS_TAG_WIDTH  = 13,
    parameter int         BURST_BEATS    = 8,
    parameter int         DEPTH          = 32,
    parameter logic [3:0] SYSBUS_MEMORY  = 4'b0001
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [63:0]               out_pc,
    output logic                      out_halt
);
    localparam int IPB        = BUS_DATA_WIDTH / 32;
    localparam int IPL        = IPB * BURST_BEATS;
    localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
    localparam int LINE_BYTES = BURST_BEATS * BEAT_BYTES;
    localparam int AW         = $clog2(DEPTH);
    localparam int BW         = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [63:0] LINE_MASK = ~(64'(LINE_BYTES) - 64'd1);
    localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG = BUS_TAG_WIDTH'({1'b1, SYSBUS_MEMORY, 8'b0});

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN} state_t;

    state_t          state_reg, state_next;
    logic [63:0]     pc_reg;
    logic [63:0]     line_base_reg;
    logic [BW-1:0]   beat_reg;
    logic            stop_reg;
    logic            redirect_pend_reg;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg;

    logic [31:0]     mem_instr [DEPTH];
    logic [63:0]     mem_pc    [DEPTH];

    logic [63:0]     beat_addr;
    logic [31:0]     lane_instr [IPB];
    logic [63:0]     lane_addr  [IPB];
    logic            lane_push  [IPB];
    logic [AW-1:0]   lane_off   [IPB];
    logic [AW:0]     n_push;
    logic            lane_kill;
    logic            zero_seen;
    logic            push_ok;
    logic            can_req;
    logic            last_beat;
    logic            pop;

    logic unused_ok;
    assign unused_ok = ^{bus_resptag, redirect_pc[1:0], entry[1:0]};

    assign beat_addr = line_base_reg + 64'(beat_reg) * 64'(BEAT_BYTES);
    assign last_beat = (beat_reg == BW'(BURST_BEATS - 1));
    // Space for a whole line is reserved before requesting, so pushes never overflow.
    assign can_req   = !stop_reg && (count_reg <= (AW+1)'(DEPTH - IPL));
    assign push_ok   = (state_reg == S_RESP) && bus_respcyc && !redirect_valid;

    genvar gi;
    generate
        for (gi = 0; gi < IPB; gi++) begin : g_lane
            assign lane_instr[gi] = bus_resp[32*gi +: 32];
            assign lane_addr[gi]  = beat_addr + 64'(4 * gi);
        end
    endgenerate

    // Lanes below the fetch PC are skipped; a zero word is kept but kills the rest of the line.
    always_comb begin
        lane_kill = stop_reg;
        zero_seen = 1'b0;
        n_push    = '0;
        for (int i = 0; i < IPB; i++) begin
            lane_push[i] = 1'b0;
            lane_off[i]  = n_push[AW-1:0];
            if (push_ok && !lane_kill && (lane_addr[i] >= pc_reg)) begin
                lane_push[i] = 1'b1;
                n_push       = n_push + (AW+1)'(1);
                if (lane_instr[i] == 32'h0) begin
                    lane_kill = 1'b1;
                    zero_seen = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!redirect_valid && can_req)
                    state_next = S_REQ;
            end
            S_REQ: begin
                bus_reqcyc = 1'b1;
                if (bus_reqack)
                    state_next = (redirect_pend_reg || redirect_valid) ? S_DRAIN : S_RESP;
            end
            S_RESP: begin
                bus_respack = bus_respcyc;
                if (bus_respcyc && last_beat)
                    state_next = S_IDLE;
                else if (redirect_valid)
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                bus_respack = bus_respcyc;
                if (bus_respcyc && last_beat)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus_req    = bus_reqcyc ? BUS_DATA_WIDTH'(line_base_reg) : '0;
    assign bus_reqtag = bus_reqcyc ? REQ_TAG : '0;

    assign out_valid = (count_reg != '0);
    assign out_instr = out_valid ? mem_instr[rd_ptr_reg] : 32'h0;
    assign out_pc    = out_valid ? mem_pc[rd_ptr_reg] : 64'h0;
    assign out_halt  = out_valid && (out_instr == 32'h0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            pc_reg            <= {entry[63:2], 2'b00};
            line_base_reg     <= '0;
            beat_reg          <= '0;
            stop_reg          <= 1'b0;
            redirect_pend_reg <= 1'b0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
        end else begin
            state_reg <= state_next;

            if (state_reg == S_IDLE && state_next == S_REQ)
                line_base_reg <= pc_reg & LINE_MASK;

            if (state_reg == S_REQ && bus_reqack)
                beat_reg <= '0;
            else if (bus_respack)
                beat_reg <= beat_reg + BW'(1);

            // Remember a redirect seen while the request is still unacknowledged.
            if (state_reg == S_REQ && !bus_reqack)
                redirect_pend_reg <= redirect_pend_reg || redirect_valid;
            else
                redirect_pend_reg <= 1'b0;

            if (redirect_valid)
                pc_reg <= {redirect_pc[63:2], 2'b00};
            else if (state_reg == S_RESP && bus_respcyc && last_beat)
                pc_reg <= line_base_reg + 64'(LINE_BYTES);

            if (redirect_valid)
                stop_reg <= 1'b0;
            else if (zero_seen)
                stop_reg <= 1'b1;

            if (redirect_valid) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                wr_ptr_reg <= wr_ptr_reg + n_push[AW-1:0];
                rd_ptr_reg <= rd_ptr_reg + AW'(pop);
                count_reg  <= count_reg + n_push - (AW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < IPB; i++) begin
            if (lane_push[i]) begin
                mem_instr[wr_ptr_reg + lane_off[i]] <= lane_instr[i];
                mem_pc[wr_ptr_reg + lane_off[i]]    <= lane_addr[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed bench for fetch_line_buffer: a bus responder plus an {instr, pc} scoreboard
// filled as beats are driven and drained as decode accepts instructions.
module tb_fetch_line_buffer;
    localparam logic [12:0] EXP_TAG = 13'h1100;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        bus_reqcyc;
    logic        bus_reqack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_halt;

    fetch_line_buffer dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_halt(out_halt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        s_reqcyc, s_respack, s_out_valid, s_out_halt;
    logic [63:0] s_req, s_out_pc;
    logic [31:0] s_out_instr;
    logic [12:0] s_tag;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [63:0] a);
        return 32'hC000_0000 ^ a[31:0];
    endfunction

    // Sample at the falling edge, score any handshake, then move just past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        s_reqcyc    = bus_reqcyc;
        s_req       = bus_req;
        s_tag       = bus_reqtag;
        s_respack   = bus_respack;
        s_out_valid = out_valid;
        s_out_halt  = out_halt;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("out_extra", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                $display("pop pc=%h instr=%h halt=%0d", out_pc, out_instr, out_halt);
                check("out_instr", 64'(out_instr), 64'(e.instr));
                check("out_pc", out_pc, e.pc);
                check("out_halt", 64'(out_halt), 64'(e.instr == 32'h0));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 64'({s_reqcyc, s_respack, s_out_valid, s_out_halt}), 64'd0);
        check({tag, "_req"}, s_req, 64'd0);
        check({tag, "_tag"}, 64'(s_tag), 64'd0);
        check({tag, "_pc"}, s_out_pc, 64'd0);
        check({tag, "_instr"}, 64'(s_out_instr), 64'd0);
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset     = 1'b1;
        entry     = e;
        out_ready = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    task automatic expect_req(input logic [63:0] exp, input int hold);
        bit seen;
        seen = 1'b0;
        bus_reqack = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            cycle();
            if (s_reqcyc) seen = 1'b1;
        end
        check("req_seen", 64'(seen), 64'd1);
        if (seen) begin
            $display("req addr=%h tag=%h", s_req, s_tag);
            check("req_addr", s_req, exp);
            check("req_tag", 64'(s_tag), 64'(EXP_TAG));
            for (int h = 0; h < hold; h++) begin
                cycle();
                check("req_hold_cyc", 64'(s_reqcyc), 64'd1);
                check("req_hold_addr", s_req, exp);
            end
            bus_reqack = 1'b1;
            cycle();
            check("req_ack_cyc", 64'(s_reqcyc), 64'd1);
            bus_reqack = 1'b0;
        end
    endtask

    task automatic send_beat(input logic [63:0] data);
        bus_respcyc = 1'b1;
        bus_resp    = data;
        cycle();
        check("respack", 64'(s_respack), 64'd1);
        bus_respcyc = 1'b0;
        bus_resp    = '0;
    endtask

    // Drive one 8-beat line; scoreboard gets every word at/after start_pc up to a zero word.
    task automatic serve_line(input logic [63:0] base, input logic [63:0] start_pc,
                              input int zero_idx, input bit chk_lat);
        logic [63:0] data;
        logic [63:0] a;
        logic [31:0] w;
        bit          halted;
        exp_t        e;
        halted = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 2; i++) begin
                a = base + 64'(8 * b + 4 * i);
                w = (2 * b + i == zero_idx) ? 32'h0 : word(a);
                data[32*i +: 32] = w;
                if (!halted && a >= start_pc) begin
                    e.instr = w;
                    e.pc    = a;
                    sb.push_back(e);
                    if (w == 32'h0) halted = 1'b1;
                end
            end
            send_beat(data);
            if (chk_lat && b == 0) check("lat_before", 64'(s_out_valid), 64'd0);
            if (chk_lat && b == 1) check("lat_after", 64'(s_out_valid), 64'd1);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 300 && sb.size() != 0; n++) cycle();
        check("sb_drained", 64'(sb.size()), 64'd0);
        repeat (3) cycle();
    endtask

    initial begin
        reset          = 1'b1;
        entry          = 64'h1000;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus_reqack     = 1'b0;
        bus_respcyc    = 1'b0;
        bus_resp       = '0;
        bus_resptag    = '0;
        out_ready      = 1'b0;
        repeat (3) cycle();
        check_zero("rst");
        reset = 1'b0;

        // T1: aligned entry, full line, request held until ack, one-cycle output latency
        out_ready = 1'b1;
        expect_req(64'h1000, 2);
        serve_line(64'h1000, 64'h1000, -1, 1'b1);
        drain();

        // T2: backpressure, request gated by free space
        do_reset(64'h1000);
        expect_req(64'h1000, 0);
        serve_line(64'h1000, 64'h1000, -1, 1'b0);
        expect_req(64'h1040, 0);
        serve_line(64'h1040, 64'h1040, -1, 1'b0);
        repeat (20) begin
            cycle();
            check("t2_full_noreq", 64'(s_reqcyc), 64'd0);
        end
        out_ready = 1'b1;
        repeat (15) cycle();
        out_ready = 1'b0;
        repeat (5) begin
            cycle();
            check("t2_15pop_noreq", 64'(s_reqcyc), 64'd0);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        expect_req(64'h1080, 0);
        out_ready = 1'b1;
        serve_line(64'h1080, 64'h1080, -1, 1'b0);
        drain();

        // T3: unaligned entry near the end of a line
        do_reset(64'h1038);
        out_ready = 1'b1;
        expect_req(64'h1000, 0);
        serve_line(64'h1000, 64'h1038, -1, 1'b0);
        expect_req(64'h1040, 0);
        serve_line(64'h1040, 64'h1040, -1, 1'b0);
        drain();

        // T4: redirect arriving with beat 3 flushes FIFO and drains the burst
        do_reset(64'h1000);
        expect_req(64'h1000, 0);
        for (int b = 0; b < 3; b++) send_beat({word(64'h1004 + 64'(8*b)), word(64'h1000 + 64'(8*b))});
        check("t4_fifo_filled", 64'(s_out_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2004;
        send_beat(64'h1111_2222_3333_4444);
        redirect_valid = 1'b0;
        for (int b = 4; b < 8; b++) begin
            send_beat(64'h5555_6666_7777_8888);
            check("t4_flushed", 64'(s_out_valid), 64'd0);
            check("t4_drain_noreq", 64'(s_reqcyc), 64'd0);
        end
        out_ready = 1'b1;
        expect_req(64'h2000, 0);
        serve_line(64'h2000, 64'h2004, -1, 1'b0);
        drain();

        // T5: zero word in beat 2 low lane halts fetch
        do_reset(64'h3000);
        out_ready = 1'b1;
        expect_req(64'h3000, 0);
        serve_line(64'h3000, 64'h3000, 4, 1'b0);
        drain();
        repeat (30) begin
            cycle();
            check("t5_halt_noreq", 64'(s_reqcyc), 64'd0);
        end

        // T6: reset in the middle of a burst, new entry reloaded
        do_reset(64'h4000);
        expect_req(64'h4000, 0);
        for (int b = 0; b < 3; b++) send_beat(64'hAAAA_0000_BBBB_0000 | 64'(b + 1));
        reset       = 1'b1;
        entry       = 64'h5008;
        bus_respcyc = 1'b1;
        bus_resp    = 64'hDEAD_BEEF_0BAD_F00D;
        cycle();
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        cycle();
        check_zero("t6_rst");
        reset     = 1'b0;
        out_ready = 1'b1;
        expect_req(64'h5000, 0);
        serve_line(64'h5000, 64'h5008, -1, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
